// File: rtl/fir_package.sv
// Shared definitions for the FIR accelerator's APB-to-periph bridge.
package fir_package;

    // Bridge transaction phases: wait for APB setup, request, await response, complete.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } fir_bridge_state_e;

    // Reads always fetch the full word.
    localparam logic [3:0] FIR_BRIDGE_RD_BE = 4'hF;

endpackage : fir_package

// File: rtl/fir_apb_periph_bridge.sv
// APB3 slave that forwards one transfer at a time to the FIR wrapper's
// periph port as a single request/grant/response transaction, with a
// response timeout that completes the APB transfer with an error.
module fir_apb_periph_bridge
    import fir_package::*;
#(
    parameter int unsigned     ID        = 10,
    parameter logic [ID-1:0]   BRIDGE_ID = '0,
    parameter int unsigned     TIMEOUT   = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          psel_i,
    input  logic          penable_i,
    input  logic          pwrite_i,
    input  logic [31:0]   paddr_i,
    input  logic [31:0]   pwdata_i,
    input  logic [3:0]    pstrb_i,
    output logic [31:0]   prdata_o,
    output logic          pready_o,
    output logic          pslverr_o,
    output logic          periph_req_o,
    input  logic          periph_gnt_i,
    output logic [31:0]   periph_add_o,
    output logic          periph_wen_o,
    output logic [3:0]    periph_be_o,
    output logic [31:0]   periph_data_o,
    output logic [ID-1:0] periph_id_o,
    input  logic [31:0]   periph_r_data_i,
    input  logic          periph_r_valid_i,
    input  logic [ID-1:0] periph_r_id_i
);

    // Counter must hold TIMEOUT itself; keep at least one bit when timeout is disabled.
    localparam int unsigned      CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT);

    fir_bridge_state_e state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pwrite_q, pwrite_d;
    logic              req_q, req_d;
    logic              wen_q, wen_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       add_q, add_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       prdata_q, prdata_d;
    logic              pslverr_q, pslverr_d;
    logic              pready_q, pready_d;

    logic              resp_match;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;

    // Next-state, capture, timeout and completion logic for the single outstanding transfer.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        pwrite_d    = pwrite_q;
        req_d       = req_q;
        wen_d       = wen_q;
        be_d        = be_q;
        add_d       = add_q;
        wdata_d     = wdata_q;
        prdata_d    = prdata_q;
        pslverr_d   = pslverr_q;
        pready_d    = 1'b0;

        resp_match  = periph_r_valid_i && (periph_r_id_i == BRIDGE_ID);
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        timeout_hit = (TIMEOUT != 0) && (cnt_inc >= TIMEOUT_LIM);

        unique case (state_q)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    pwrite_d = pwrite_i;
                    add_d    = paddr_i;
                    wdata_d  = pwdata_i;
                    be_d     = pwrite_i ? pstrb_i : FIR_BRIDGE_RD_BE;
                    wen_d    = ~pwrite_i;
                    cnt_d    = '0;
                    req_d    = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_inc;
                if (periph_gnt_i && resp_match) begin
                    req_d     = 1'b0;
                    prdata_d  = pwrite_q ? 32'h0 : periph_r_data_i;
                    pslverr_d = 1'b0;
                    pready_d  = 1'b1;
                    state_d   = DONE;
                end else if (timeout_hit) begin
                    req_d     = 1'b0;
                    prdata_d  = 32'h0;
                    pslverr_d = 1'b1;
                    pready_d  = 1'b1;
                    state_d   = DONE;
                end else if (periph_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d = cnt_inc;
                if (resp_match) begin
                    prdata_d  = pwrite_q ? 32'h0 : periph_r_data_i;
                    pslverr_d = 1'b0;
                    pready_d  = 1'b1;
                    state_d   = DONE;
                end else if (timeout_hit) begin
                    prdata_d  = 32'h0;
                    pslverr_d = 1'b1;
                    pready_d  = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset clears everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: registers use non-blocking assignments so all flops update from the same pre-edge values.
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pwrite_q  <= 1'b0;
            req_q     <= 1'b0;
            wen_q     <= 1'b0;
            be_q      <= 4'h0;
            add_q     <= 32'h0;
            wdata_q   <= 32'h0;
            prdata_q  <= 32'h0;
            pslverr_q <= 1'b0;
            pready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pwrite_q  <= pwrite_d;
            req_q     <= req_d;
            wen_q     <= wen_d;
            be_q      <= be_d;
            add_q     <= add_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            pready_q  <= pready_d;
        end
    end

    assign prdata_o      = prdata_q;
    assign pready_o      = pready_q;
    assign pslverr_o     = pslverr_q;
    assign periph_req_o  = req_q;
    assign periph_add_o  = add_q;
    assign periph_wen_o  = wen_q;
    assign periph_be_o   = be_q;
    assign periph_data_o = wdata_q;
    assign periph_id_o   = BRIDGE_ID;

endmodule : fir_apb_periph_bridge

// File: tb/tb_fir_apb_periph_bridge.sv
// Self-checking bench for fir_apb_periph_bridge with a short timeout.
module tb_fir_apb_periph_bridge;

    localparam int unsigned   ID        = 10;
    localparam logic [ID-1:0] BRIDGE_ID = 10'd3;
    localparam logic [ID-1:0] OTHER_ID  = 10'd0;
    localparam int unsigned   TIMEOUT   = 8;
    localparam int            BUDGET    = 60;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          psel_i, penable_i, pwrite_i;
    logic [31:0]   paddr_i, pwdata_i;
    logic [3:0]    pstrb_i;
    logic [31:0]   prdata_o;
    logic          pready_o, pslverr_o;
    logic          periph_req_o, periph_gnt_i;
    logic [31:0]   periph_add_o;
    logic          periph_wen_o;
    logic [3:0]    periph_be_o;
    logic [31:0]   periph_data_o;
    logic [ID-1:0] periph_id_o;
    logic [31:0]   periph_r_data_i;
    logic          periph_r_valid_i;
    logic [ID-1:0] periph_r_id_i;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] prdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk_i = ~clk_i;

    fir_apb_periph_bridge #(
        .ID        (ID),
        .BRIDGE_ID (BRIDGE_ID),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .psel_i           (psel_i),
        .penable_i        (penable_i),
        .pwrite_i         (pwrite_i),
        .paddr_i          (paddr_i),
        .pwdata_i         (pwdata_i),
        .pstrb_i          (pstrb_i),
        .prdata_o         (prdata_o),
        .pready_o         (pready_o),
        .pslverr_o        (pslverr_o),
        .periph_req_o     (periph_req_o),
        .periph_gnt_i     (periph_gnt_i),
        .periph_add_o     (periph_add_o),
        .periph_wen_o     (periph_wen_o),
        .periph_be_o      (periph_be_o),
        .periph_data_o    (periph_data_o),
        .periph_id_o      (periph_id_o),
        .periph_r_data_i  (periph_r_data_i),
        .periph_r_valid_i (periph_r_valid_i),
        .periph_r_id_i    (periph_r_id_i)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One APB transfer starting in the current cycle (T). gnt_wait = stall cycles
    // before grant; resp_wait = cycles after grant for the matching response
    // (0 = same cycle, -1 = never); bad_at = cycle of a wrong-ID response (0 = none).
    // Returns pready latency in cycles after T (-1 if the budget expires).
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input int gnt_wait, input int resp_wait,
                            input int bad_at, input logic [31:0] rdata,
                            output int lat, output logic [31:0] prd, output logic err,
                            output int req_cycles, output logic fields_ok);
        logic [3:0] be_exp;
        be_exp     = wr ? strb : 4'hF;
        lat        = -1;
        prd        = 32'hX;
        err        = 1'bX;
        req_cycles = 0;
        fields_ok  = 1'b1;
        psel_i     = 1'b1;
        penable_i  = 1'b0;
        pwrite_i   = wr;
        paddr_i    = addr;
        pwdata_i   = wdata;
        pstrb_i    = strb;
        for (int c = 1; c <= BUDGET; c++) begin
            step();
            penable_i        = 1'b1;
            periph_gnt_i     = 1'b0;
            periph_r_valid_i = 1'b0;
            periph_r_id_i    = BRIDGE_ID;
            periph_r_data_i  = 32'h0;
            if (pready_o) begin
                lat = c;
                prd = prdata_o;
                err = pslverr_o;
                break;
            end
            if (periph_req_o) begin
                req_cycles++;
                if (periph_add_o !== addr || periph_wen_o !== ~wr || periph_be_o !== be_exp ||
                    periph_data_o !== wdata || periph_id_o !== BRIDGE_ID)
                    fields_ok = 1'b0;
            end
            if (c == 1 + gnt_wait) periph_gnt_i = 1'b1;
            if (resp_wait >= 0 && c == 1 + gnt_wait + resp_wait) begin
                periph_r_valid_i = 1'b1;
                periph_r_data_i  = rdata;
            end else if (bad_at != 0 && c == bad_at) begin
                periph_r_valid_i = 1'b1;
                periph_r_id_i    = OTHER_ID;
                periph_r_data_i  = 32'hBAD0BAD0;
            end
        end
        psel_i           = 1'b0;
        penable_i        = 1'b0;
        periph_gnt_i     = 1'b0;
        periph_r_valid_i = 1'b0;
        step();
    endtask

    // Pop the scoreboard entry for the transfer just finished and compare.
    task automatic compare_result(input string name, input int lat, input logic [31:0] prd,
                                  input logic err);
        exp_t e;
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb_q.pop_front();
        tests_run++;
        if (lat !== e.lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
        end
        tests_run++;
        if (prd !== e.prdata || err !== e.err) begin
            tests_failed++;
            $display("FAIL %s result: got prdata=%h err=%b expected prdata=%h err=%b",
                     name, prd, err, e.prdata, e.err);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (prdata_o !== 32'h0 || pready_o !== 1'b0 || pslverr_o !== 1'b0 || periph_req_o !== 1'b0 ||
            periph_add_o !== 32'h0 || periph_wen_o !== 1'b0 || periph_be_o !== 4'h0 ||
            periph_data_o !== 32'h0 || periph_id_o !== BRIDGE_ID) begin
            tests_failed++;
            $display("FAIL reset_values: got req=%b wen=%b be=%h add=%h data=%h id=%0d prdata=%h rdy=%b err=%b",
                     periph_req_o, periph_wen_o, periph_be_o, periph_add_o, periph_data_o,
                     periph_id_o, prdata_o, pready_o, pslverr_o);
        end
    endtask

    task automatic test_write();
        int lat, rc; logic [31:0] prd; logic err, fok;
        sb_q.push_back('{prdata: 32'h0, err: 1'b0, lat: 3});
        apb_xfer(1'b1, 32'h20, 32'hDEADBEEF, 4'h3, 0, 1, 0, 32'h0, lat, prd, err, rc, fok);
        tests_run++;
        if (rc !== 1 || fok !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_req: req_cycles=%0d fields_ok=%b expected 1 and 1", rc, fok);
        end
        compare_result("write", lat, prd, err);
    endtask

    task automatic test_read_stall();
        int lat, rc; logic [31:0] prd; logic err, fok;
        sb_q.push_back('{prdata: 32'h12345678, err: 1'b0, lat: 7});
        apb_xfer(1'b0, 32'h04, 32'h0000CAFE, 4'h0, 4, 1, 0, 32'h12345678, lat, prd, err, rc, fok);
        tests_run++;
        if (rc !== 5 || fok !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_stall_req: req_cycles=%0d fields_ok=%b expected 5 and 1", rc, fok);
        end
        compare_result("read_stall", lat, prd, err);
    endtask

    task automatic test_same_cycle();
        int lat, rc; logic [31:0] prd; logic err, fok;
        sb_q.push_back('{prdata: 32'hA5A55A5A, err: 1'b0, lat: 2});
        apb_xfer(1'b0, 32'h08, 32'h0, 4'hF, 0, 0, 0, 32'hA5A55A5A, lat, prd, err, rc, fok);
        compare_result("same_cycle", lat, prd, err);
    endtask

    task automatic test_timeout();
        int lat, rc; logic [31:0] prd; logic err, fok;
        // Granted but never answered: error on cycle T+TIMEOUT+1.
        sb_q.push_back('{prdata: 32'h0, err: 1'b1, lat: TIMEOUT + 1});
        apb_xfer(1'b0, 32'h0C, 32'h0, 4'h0, 0, -1, 0, 32'h0, lat, prd, err, rc, fok);
        compare_result("timeout_resp", lat, prd, err);
        // Never granted: req stays up for exactly TIMEOUT cycles then drops.
        sb_q.push_back('{prdata: 32'h0, err: 1'b1, lat: TIMEOUT + 1});
        apb_xfer(1'b1, 32'h10, 32'h11112222, 4'h5, 100, -1, 0, 32'h0, lat, prd, err, rc, fok);
        tests_run++;
        if (rc !== int'(TIMEOUT) || periph_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_req_drop: req_cycles=%0d req=%b expected %0d and 0", rc, periph_req_o, TIMEOUT);
        end
        compare_result("timeout_gnt", lat, prd, err);
        // Following transfer completes normally.
        sb_q.push_back('{prdata: 32'h0F0F0F0F, err: 1'b0, lat: 3});
        apb_xfer(1'b0, 32'h14, 32'h0, 4'h0, 0, 1, 0, 32'h0F0F0F0F, lat, prd, err, rc, fok);
        compare_result("after_timeout", lat, prd, err);
    endtask

    task automatic test_wrong_id();
        int lat, rc; logic [31:0] prd; logic err, fok;
        // Grant at c=1, wrong ID at c=2, matching response at c=4 -> pready at c=5.
        sb_q.push_back('{prdata: 32'hC0FFEE01, err: 1'b0, lat: 5});
        apb_xfer(1'b0, 32'h18, 32'h0, 4'h0, 0, 3, 2, 32'hC0FFEE01, lat, prd, err, rc, fok);
        compare_result("wrong_id", lat, prd, err);
    endtask

    task automatic test_back_to_back();
        int lat, rc; logic [31:0] prd; logic err, fok;
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            sb_q.push_back('{prdata: (i % 2 == 0) ? d : 32'h0, err: 1'b0, lat: 3 + i});
            apb_xfer(i % 2 != 0, 32'h100 + 32'(4 * i), d, 4'(i + 1), i, 1, 0, d, lat, prd, err, rc, fok);
            tests_run++;
            if (fok !== 1'b1 || rc !== 1 + i) begin
                tests_failed++;
                $display("FAIL b2b_req[%0d]: req_cycles=%0d fields_ok=%b expected %0d and 1", i, rc, fok, 1 + i);
            end
            compare_result("b2b", lat, prd, err);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
        paddr_i   = 32'h40;
        pwdata_i  = 32'h0;
        pstrb_i   = 4'h0;
        step();                       // REQ
        penable_i    = 1'b1;
        periph_gnt_i = 1'b1;
        step();                       // RESP
        periph_gnt_i = 1'b0;
        rst_i = 1'b1;
        #1;
        tests_run++;
        if (prdata_o !== 32'h0 || pready_o !== 1'b0 || pslverr_o !== 1'b0 || periph_req_o !== 1'b0 ||
            periph_add_o !== 32'h0 || periph_wen_o !== 1'b0 || periph_be_o !== 4'h0 ||
            periph_data_o !== 32'h0 || periph_id_o !== BRIDGE_ID) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: req=%b wen=%b be=%h add=%h prdata=%h rdy=%b err=%b",
                     periph_req_o, periph_wen_o, periph_be_o, periph_add_o, prdata_o, pready_o, pslverr_o);
        end
        psel_i    = 1'b0;
        penable_i = 1'b0;
        step();
        rst_i = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            periph_r_valid_i = 1'b1;
            periph_r_id_i    = BRIDGE_ID;
            periph_r_data_i  = 32'h77778888;
            step();
            if (pready_o || periph_req_o) seen = 1'b1;
        end
        periph_r_valid_i = 1'b0;
        tests_run++;
        if (seen !== 1'b0 || prdata_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_late_resp: activity=%b prdata=%h expected 0 and 0", seen, prdata_o);
        end
    endtask

    initial begin
        rst_i            = 1'b1;
        psel_i           = 1'b0;
        penable_i        = 1'b0;
        pwrite_i         = 1'b0;
        paddr_i          = 32'h0;
        pwdata_i         = 32'h0;
        pstrb_i          = 4'h0;
        periph_gnt_i     = 1'b0;
        periph_r_valid_i = 1'b0;
        periph_r_id_i    = '0;
        periph_r_data_i  = 32'h0;
        repeat (3) step();
        test_reset();
        rst_i = 1'b0;
        step();
        test_write();
        test_read_stall();
        test_same_cycle();
        test_timeout();
        test_wrong_id();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_fir_apb_periph_bridge
